// File: rtl/dram_pair_arbiter.sv
// Round-robin arbiter sharing the paired k/l DRAM read-request path; routes responses back in issue order.
// Grant is combinational, request-FIFO write and response strobe are registered one cycle later.

// Generic synchronous FIFO with occupancy count.
// Write accepted when wr_rdy (not full); read side shows head whenever rd_vld.
module pair_arb_fifo #(
    parameter int W     = 2,
    parameter int DEPTH = 16
) (
    input  logic                     CLK_200M,
    input  logic                     reset_n,
    input  logic                     clear,
    input  logic                     wr_vld,
    input  logic [W-1:0]             wr_dat,
    output logic                     wr_rdy,
    output logic                     rd_vld,
    output logic [W-1:0]             rd_dat,
    input  logic                     rd_rdy,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_wr;
    logic          do_rd;

    assign wr_rdy = (count != CW'(DEPTH));
    assign rd_vld = (count != '0);
    assign rd_dat = mem[rd_ptr];
    assign do_wr  = wr_vld && wr_rdy;
    assign do_rd  = rd_rdy && rd_vld;

    always_ff @(posedge CLK_200M) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_dat;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge CLK_200M) begin
        if (!reset_n || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// Top: one address pair per cycle, stalled by TX almost-full or a full tag FIFO.
// Tag FIFO records the winning port so each returned pair is steered to its issuer.
module dram_pair_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 58,
    parameter int MAX_OUT = 16
) (
    input  logic                        CLK_200M,
    input  logic                        reset_n,
    input  logic                        clear,
    input  logic                        stall,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr_k,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr_l,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic                        fifo_wr_en,
    output logic [ADDR_W-1:0]           fifo_addr_k,
    output logic [ADDR_W-1:0]           fifo_addr_l,
    input  logic                        rsp_pair_valid,
    input  logic [511:0]                rsp_k,
    input  logic [511:0]                rsp_l,
    output logic [NUM_REQ-1:0]          rsp_valid,
    output logic [511:0]                rsp_data_k,
    output logic [511:0]                rsp_data_l,
    output logic [$clog2(MAX_OUT):0]    outstanding,
    output logic                        busy,
    output logic                        err_orphan
);
    localparam int ID_W = $clog2(NUM_REQ);

    typedef struct packed {
        logic [ADDR_W-1:0] k;
        logic [ADDR_W-1:0] l;
    } addr_pair_t;

    logic [ID_W-1:0] rr;
    logic [ID_W-1:0] win_id;
    logic            win_vld;
    logic            grant_vld;
    logic            tag_wr_rdy;
    logic            tag_rd_vld;
    logic [ID_W-1:0] tag_head;
    logic            rsp_tagged;
    addr_pair_t      win_pair;
    addr_pair_t      fifo_pair;

    // First requester at or above rr, wrapping modulo NUM_REQ.
    always_comb begin
        logic [ID_W:0]   sum;
        logic [ID_W-1:0] idx;
        win_vld = 1'b0;
        win_id  = '0;
        sum     = '0;
        idx     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, rr} + (ID_W+1)'(k);
            if (sum >= (ID_W+1)'(NUM_REQ)) begin
                sum = sum - (ID_W+1)'(NUM_REQ);
            end
            idx = sum[ID_W-1:0];
            if (!win_vld && req_valid[idx]) begin
                win_vld = 1'b1;
                win_id  = idx;
            end
        end
    end

    // tag_wr_rdy low means MAX_OUT pairs are in flight; a same-cycle retirement gives no credit.
    assign grant_vld  = reset_n && !clear && !stall && tag_wr_rdy && win_vld;
    assign req_ready  = grant_vld ? (NUM_REQ'(1) << win_id) : '0;
    assign win_pair.k = req_addr_k[win_id*ADDR_W +: ADDR_W];
    assign win_pair.l = req_addr_l[win_id*ADDR_W +: ADDR_W];
    assign rsp_tagged = rsp_pair_valid && tag_rd_vld;

    pair_arb_fifo #(
        .W     (ID_W),
        .DEPTH (MAX_OUT)
    ) u_tag_fifo (
        .CLK_200M (CLK_200M),
        .reset_n  (reset_n),
        .clear    (clear),
        .wr_vld   (grant_vld),
        .wr_dat   (win_id),
        .wr_rdy   (tag_wr_rdy),
        .rd_vld   (tag_rd_vld),
        .rd_dat   (tag_head),
        .rd_rdy   (rsp_pair_valid),
        .count    (outstanding)
    );

    assign busy        = (outstanding != '0);
    assign fifo_addr_k = fifo_pair.k;
    assign fifo_addr_l = fifo_pair.l;

    always_ff @(posedge CLK_200M) begin
        if (!reset_n || clear) begin
            rr         <= '0;
            fifo_wr_en <= 1'b0;
            fifo_pair  <= '0;
            rsp_valid  <= '0;
            rsp_data_k <= '0;
            rsp_data_l <= '0;
            err_orphan <= 1'b0;
        end else begin
            fifo_wr_en <= grant_vld;
            if (grant_vld) begin
                fifo_pair <= win_pair;
                rr        <= (win_id == ID_W'(NUM_REQ - 1)) ? '0 : win_id + ID_W'(1);
            end
            rsp_valid <= rsp_tagged ? (NUM_REQ'(1) << tag_head) : '0;
            if (rsp_tagged) begin
                rsp_data_k <= rsp_k;
                rsp_data_l <= rsp_l;
            end
            if (rsp_pair_valid && !tag_rd_vld) begin
                err_orphan <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_dram_pair_arbiter.sv
// Directed bench for dram_pair_arbiter: round-robin order, credit limit, stall, orphan and clear.
`timescale 1ns/1ps
module tb_dram_pair_arbiter;
    localparam int NR = 4;
    localparam int AW = 58;
    localparam int MO = 16;

    logic              CLK_200M = 1'b0;
    logic              reset_n;
    logic              clear;
    logic              stall;
    logic [NR-1:0]     req_valid;
    logic [NR*AW-1:0]  req_addr_k;
    logic [NR*AW-1:0]  req_addr_l;
    logic [NR-1:0]     req_ready;
    logic              fifo_wr_en;
    logic [AW-1:0]     fifo_addr_k;
    logic [AW-1:0]     fifo_addr_l;
    logic              rsp_pair_valid;
    logic [511:0]      rsp_k;
    logic [511:0]      rsp_l;
    logic [NR-1:0]     rsp_valid;
    logic [511:0]      rsp_data_k;
    logic [511:0]      rsp_data_l;
    logic [4:0]        outstanding;
    logic              busy;
    logic              err_orphan;

    int n_chk  = 0;
    int n_pass = 0;

    always #2.5 CLK_200M = ~CLK_200M;

    dram_pair_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .MAX_OUT(MO)) dut (
        .CLK_200M       (CLK_200M),
        .reset_n        (reset_n),
        .clear          (clear),
        .stall          (stall),
        .req_valid      (req_valid),
        .req_addr_k     (req_addr_k),
        .req_addr_l     (req_addr_l),
        .req_ready      (req_ready),
        .fifo_wr_en     (fifo_wr_en),
        .fifo_addr_k    (fifo_addr_k),
        .fifo_addr_l    (fifo_addr_l),
        .rsp_pair_valid (rsp_pair_valid),
        .rsp_k          (rsp_k),
        .rsp_l          (rsp_l),
        .rsp_valid      (rsp_valid),
        .rsp_data_k     (rsp_data_k),
        .rsp_data_l     (rsp_data_l),
        .outstanding    (outstanding),
        .busy           (busy),
        .err_orphan     (err_orphan)
    );

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK_200M);
        #1;
    endtask

    task automatic set_addr(input int p, input logic [AW-1:0] k, input logic [AW-1:0] l);
        req_addr_k[p*AW +: AW] = k;
        req_addr_l[p*AW +: AW] = l;
    endtask

    int exp_port[$];

    initial begin
        reset_n        = 1'b0;
        clear          = 1'b0;
        stall          = 1'b0;
        req_valid      = '1;
        req_addr_k     = '0;
        req_addr_l     = '0;
        rsp_pair_valid = 1'b0;
        rsp_k          = '0;
        rsp_l          = '0;
        for (int p = 0; p < NR; p++) set_addr(p, AW'(58'h1000 + p), AW'(58'h2000 + p));

        // Reset state
        step();
        step();
        check("rst_req_ready", req_ready, 0);
        check("rst_wr_en", fifo_wr_en, 0);
        check("rst_addr_k", fifo_addr_k, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_outstanding", outstanding, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err_orphan, 0);

        // All ports valid: grants 0,1,2,3,... until 16 outstanding
        reset_n = 1'b1;
        for (int g = 0; g < MO; g++) begin
            #1;
            check("rr_ready", req_ready, 4'b1 << (g % 4));
            step();
            check("rr_wr_en", fifo_wr_en, 1);
            check("rr_addr_k", fifo_addr_k, 58'h1000 + (g % 4));
            check("rr_addr_l", fifo_addr_l, 58'h2000 + (g % 4));
            check("rr_outstanding", outstanding, g + 1);
        end
        #1;
        check("full_ready", req_ready, 0);
        check("full_busy", busy, 1);

        // Full: response and port1 request in the same cycle -> no grant yet
        req_valid      = 4'b0010;
        rsp_pair_valid = 1'b1;
        rsp_k          = 512'hABCD_0001;
        rsp_l          = 512'hDCBA_0001;
        #1;
        check("full_rsp_ready", req_ready, 0);
        step();
        check("full_rsp_wr_en", fifo_wr_en, 0);
        check("full_rsp_out15", outstanding, 15);
        check("full_rsp_valid", rsp_valid, 4'b0001);
        check("full_rsp_dk", rsp_data_k, 512'hABCD_0001);
        check("full_rsp_dl", rsp_data_l, 512'hDCBA_0001);
        rsp_pair_valid = 1'b0;
        #1;
        check("refill_ready", req_ready, 4'b0010);
        step();
        check("refill_wr_en", fifo_wr_en, 1);
        check("refill_addr_k", fifo_addr_k, 58'h1001);
        check("refill_out16", outstanding, 16);
        check("rsp_pulse", rsp_valid, 0);
        req_valid = '0;

        // Drain in issue order
        for (int g = 1; g < MO; g++) exp_port.push_back(g % 4);
        exp_port.push_back(1);
        for (int i = 0; i < MO; i++) begin
            rsp_pair_valid = 1'b1;
            rsp_k          = 512'(i + 32'h50);
            rsp_l          = 512'(i + 32'h90);
            step();
            check("drain_valid", rsp_valid, 4'b1 << exp_port[i]);
            check("drain_dk", rsp_data_k, 512'(i + 32'h50));
        end
        rsp_pair_valid = 1'b0;
        check("drain_out0", outstanding, 0);
        check("drain_busy", busy, 0);
        check("drain_err", err_orphan, 0);

        // Port2 then port0, responses routed back in order
        set_addr(2, 58'h100, 58'h200);
        set_addr(0, 58'h300, 58'h304);
        req_valid = 4'b0100;
        #1;
        check("p2_ready", req_ready, 4'b0100);
        step();
        check("p2_addr_k", fifo_addr_k, 58'h100);
        check("p2_addr_l", fifo_addr_l, 58'h200);
        req_valid = 4'b0001;
        #1;
        check("p0_ready", req_ready, 4'b0001);
        step();
        check("p0_addr_k", fifo_addr_k, 58'h300);
        check("p0_addr_l", fifo_addr_l, 58'h304);
        check("p20_out2", outstanding, 2);
        req_valid      = '0;
        rsp_pair_valid = 1'b1;
        rsp_k          = 512'h1111;
        rsp_l          = 512'h2222;
        step();
        check("p2_rsp_valid", rsp_valid, 4'b0100);
        check("p2_rsp_dk", rsp_data_k, 512'h1111);
        check("p2_rsp_dl", rsp_data_l, 512'h2222);
        rsp_k = 512'h3333;
        rsp_l = 512'h4444;
        step();
        check("p0_rsp_valid", rsp_valid, 4'b0001);
        check("p0_rsp_dk", rsp_data_k, 512'h3333);
        check("p0_rsp_dl", rsp_data_l, 512'h4444);
        rsp_pair_valid = 1'b0;
        step();
        check("p20_pulse", rsp_valid, 0);
        check("p20_out0", outstanding, 0);

        // Stall for 5 cycles with port3 valid
        stall     = 1'b1;
        req_valid = 4'b1000;
        for (int c = 0; c < 5; c++) begin
            #1;
            check("stall_ready", req_ready, 0);
            step();
            check("stall_wr_en", fifo_wr_en, 0);
        end
        stall = 1'b0;
        #1;
        check("unstall_ready", req_ready, 4'b1000);
        step();
        check("unstall_wr_en", fifo_wr_en, 1);
        req_valid      = '0;
        rsp_pair_valid = 1'b1;
        step();
        check("p3_rsp_valid", rsp_valid, 4'b1000);
        rsp_pair_valid = 1'b0;

        // Orphan response with nothing outstanding
        step();
        check("pre_orphan_out", outstanding, 0);
        rsp_pair_valid = 1'b1;
        step();
        check("orphan_valid", rsp_valid, 0);
        check("orphan_err", err_orphan, 1);
        check("orphan_out", outstanding, 0);
        rsp_pair_valid = 1'b0;
        step();
        step();
        check("orphan_sticky", err_orphan, 1);

        // Clear with 7 outstanding; rr ends at 3 before the clear
        req_valid = '1;
        for (int g = 0; g < 7; g++) step();
        req_valid = '0;
        check("pre_clear_out", outstanding, 7);
        clear = 1'b1;
        step();
        clear = 1'b0;
        check("clear_out", outstanding, 0);
        check("clear_busy", busy, 0);
        check("clear_err", err_orphan, 0);
        check("clear_wr_en", fifo_wr_en, 0);
        req_valid = 4'b1010;
        #1;
        check("clear_rr0_ready", req_ready, 4'b0010);
        step();
        check("post_clear_out", outstanding, 1);
        req_valid = '0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
